// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter for COUNT bus sources.
//
// Drives a registered one-hot enable vector straight into the bus mux, so
// at most one source ever drives the bus. The current owner keeps the grant
// for as long as it keeps requesting. When it drops its request, the grant
// passes on the same edge to the next requester in round-robin order.
//
// Optional macro BUS_ARB_TIMEOUT_EN: when defined, an owner that has held
// the bus for MAX_HOLD consecutive cycles is forced to give it up, but only
// if another source is waiting.
//
// Ports:
//   clk         system clock; all state changes on posedge
//   reset       synchronous, active-high reset
//   req         per-source request, bit i = source i
//   enable      registered one-hot grant (or all-zero)
//   grant_index 0 when idle, otherwise granted source + 1
//   busy        high while any grant is active (== |enable)
module bus_arbiter #(
    parameter int COUNT    = 8,
    parameter int MAX_HOLD = 16,
    localparam int ENC_WIDTH = $clog2(COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COUNT-1:0]     req,
    output logic [COUNT-1:0]     enable,
    output logic [ENC_WIDTH-1:0] grant_index,
    output logic                 busy
);
    localparam int IDX_W = $clog2(COUNT);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [COUNT-1:0] mask;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             take;
    logic             timeout;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
`endif

    // The owner is always masked out of the search. A held owner never
    // reaches the search. A dropped owner has req=0 anyway. A timed-out
    // owner must be skipped even if it is still requesting.
    always_comb begin
        mask = req;
        if (state == GRANT)
            mask[owner] = 1'b0;
    end

    // Round-robin search: start at rr_ptr and wrap around modulo COUNT.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < COUNT; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= COUNT)
                idx = idx - COUNT;
            if (!win_found && mask[idx]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    assign timeout = (state == GRANT) && (hold_cnt == HOLD_LAST) && win_found;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (win_found)
                    take = 1'b1;
            end
            GRANT: begin
                if (!(req[owner] && !timeout)) begin
                    if (win_found)
                        take = 1'b1;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (take) begin
            state_nxt  = GRANT;
            owner_nxt  = win_idx;
            rr_ptr_nxt = (int'(win_idx) == COUNT - 1) ? '0 : win_idx + 1'b1;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    // Counts the cycles of the current grant. It saturates, so an owner with
    // no competitors never wraps the counter back to zero.
    always_comb begin
        hold_cnt_nxt = '0;
        if (state_nxt == GRANT && !take)
            hold_cnt_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            enable      <= '0;
            grant_index <= '0;
            busy        <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (state_nxt == GRANT) begin
                enable      <= COUNT'(1) << owner_nxt;
                grant_index <= ENC_WIDTH'(owner_nxt) + 1'b1;
                busy        <= 1'b1;
            end else begin
                enable      <= '0;
                grant_index <= '0;
                busy        <= 1'b0;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt_nxt;
`endif
        end
    end
endmodule
